// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the dmem bus shared by dmem_arbiter.
// master = requesters plus memory model, slave = the arbiter.
interface dmem_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
);
  logic              req0, req1;
  logic              wr0, wr1;
  logic [0:ADDR_W-1] addr0, addr1;
  logic [0:DATA_W-1] wdata0, wdata1;
  logic              lock1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [0:DATA_W-1] rdata0, rdata1;
  logic              memEn;
  logic              memWrEn;
  logic [0:ADDR_W-1] memAddr;
  logic [0:DATA_W-1] memDataIn;
  logic [0:DATA_W-1] mem_dout;

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, lock1, mem_dout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           memEn, memWrEn, memAddr, memDataIn
  );

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, lock1, mem_dout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           memEn, memWrEn, memAddr, memDataIn
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the single-ported dmem: processor on port 0,
// NI/DMA on port 1 with bounded lock bursts. Registered command, 2-cycle read return.
module dmem_arbiter #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  logic              last;
  logic [CNT_W-1:0]  burst_cnt;
  logic              locked;
  logic              win0, win1;

  logic              mem_en_q, mem_wr_q;
  logic [0:ADDR_W-1] mem_addr_q;
  logic [0:DATA_W-1] mem_data_q;

  // Read return pipe: stage 1 tracks the command on the bus, stage 2 is rvalid.
  logic              rd_valid_q, rd_port_q;
  logic              rvalid0_q, rvalid1_q;

  assign locked = bus.req1 && bus.lock1 && (burst_cnt < BURST_MAX);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    win0 = 1'b0;
    win1 = 1'b1 & 1'b0;
    if (reset) begin
      if (locked) begin
        win1 = 1'b1;
      end else if (bus.req0 && bus.req1) begin
        if (last == PORT1) win0 = 1'b1;
        else               win1 = 1'b1;
      end else if (bus.req0) begin
        win0 = 1'b1;
      end else if (bus.req1) begin
        win1 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      last       <= PORT1;
      burst_cnt  <= '0;
      rd_valid_q <= 1'b0;
      rd_port_q  <= PORT0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      mem_en_q <= win0 || win1;
      if (win0) begin
        mem_wr_q   <= bus.wr0;
        mem_addr_q <= bus.addr0;
        mem_data_q <= bus.wdata0;
        last       <= PORT0;
      end else if (win1) begin
        mem_wr_q   <= bus.wr1;
        mem_addr_q <= bus.addr1;
        mem_data_q <= bus.wdata1;
        last       <= PORT1;
      end else begin
        mem_wr_q   <= 1'b0;
      end

      rd_valid_q <= (win0 && !bus.wr0) || (win1 && !bus.wr1);
      rd_port_q  <= win1;
      rvalid0_q  <= rd_valid_q && (rd_port_q == PORT0);
      rvalid1_q  <= rd_valid_q && (rd_port_q == PORT1);

      // A forced yield to port 0 ends the burst; dropping lock or request also ends it.
      if (!(bus.req1 && bus.lock1) || win0) begin
        burst_cnt <= '0;
      end else if (win1 && (burst_cnt != BURST_MAX)) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

  assign bus.gnt0      = win0;
  assign bus.gnt1      = win1;
  assign bus.memEn     = mem_en_q;
  assign bus.memWrEn   = mem_wr_q;
  assign bus.memAddr   = mem_addr_q;
  assign bus.memDataIn = mem_data_q;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata0    = bus.mem_dout;
  assign bus.rdata1    = bus.mem_dout;

  rvalid_exclusive: assert property (@(posedge clk) disable iff (!reset)
    !(rvalid0_q && rvalid1_q));
  gnt_exclusive: assert property (@(posedge clk) disable iff (!reset)
    !(win0 && win1));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous dmem model on the bus.
module tb_dmem_arbiter;
  localparam int DATA_W    = 64;
  localparam int ADDR_W    = 32;
  localparam int MAX_BURST = 4;

  localparam logic [0:DATA_W-1] D_SOLO = 64'h0123_4567_89AB_CDEF;
  localparam logic [0:DATA_W-1] D_XPORT = 64'hFEED_F00D_CAFE_BEEF;
  localparam logic [0:DATA_W-1] D_BASE = 64'hA5A5_0000_0000_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous dmem: write or launch a read on each enabled rising edge.
  logic [0:DATA_W-1] mem [256];
  always @(posedge clk) begin
    if (bus.memEn) begin
      if (bus.memWrEn) mem[bus.memAddr[24:31]] <= bus.memDataIn;
      else             bus.mem_dout <= mem[bus.memAddr[24:31]];
    end
  end

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lock1 = 1'b0;
    bus.wr0 = 1'b0;  bus.wr1 = 1'b0;
    bus.addr0 = '0;  bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.gnt0, bus.gnt1, bus.memEn, bus.rvalid0, bus.rvalid1} !== 5'b00000) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: gnt0,gnt1,memEn,rvalid0,rvalid1 got %b want 00000", i,
                 {bus.gnt0, bus.gnt1, bus.memEn, bus.rvalid0, bus.rvalid1});
      end
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_first_tie: gnt0,gnt1 got %b want 10", {bus.gnt0, bus.gnt1});
    end
    @(negedge clk);
    idle_inputs();
    vectors++;
    if (bus.memEn !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_cmd: memEn got %b want 1", bus.memEn);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_solo_write_read();
    @(negedge clk);
    bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 32'h10; bus.wdata0 = D_SOLO;
    #1;
    vectors++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      miscompares++;
      $display("FAIL solo_wr_gnt: gnt0,gnt1 got %b want 10", {bus.gnt0, bus.gnt1});
    end
    @(negedge clk);
    vectors++;
    if ({bus.memEn, bus.memWrEn} !== 2'b11 || bus.memAddr !== 32'h10 || bus.memDataIn !== D_SOLO) begin
      miscompares++;
      $display("FAIL solo_wr_cmd: en,we got %b addr %h data %h want 11 addr 00000010 data %h",
               {bus.memEn, bus.memWrEn}, bus.memAddr, bus.memDataIn, D_SOLO);
    end
    bus.wr0 = 1'b0;
    #1;
    vectors++;
    if (bus.gnt0 !== 1'b1) begin
      miscompares++;
      $display("FAIL solo_rd_gnt: gnt0 got %b want 1", bus.gnt0);
    end
    @(negedge clk);
    idle_inputs();
    vectors++;
    if ({bus.memEn, bus.memWrEn} !== 2'b10 || bus.memAddr !== 32'h10) begin
      miscompares++;
      $display("FAIL solo_rd_cmd: en,we got %b addr %h want 10 addr 00000010",
               {bus.memEn, bus.memWrEn}, bus.memAddr);
    end
    @(negedge clk);
    vectors++;
    if ({bus.rvalid0, bus.rvalid1} !== 2'b10 || bus.rdata0 !== D_SOLO) begin
      miscompares++;
      $display("FAIL solo_rd_data: rvalid0,rvalid1 got %b rdata0 %h want 10 rdata0 %h",
               {bus.rvalid0, bus.rvalid1}, bus.rdata0, D_SOLO);
    end
    @(negedge clk);
    vectors++;
    if ({bus.rvalid0, bus.rvalid1} !== 2'b00) begin
      miscompares++;
      $display("FAIL solo_rvalid_pulse: rvalid0,rvalid1 got %b want 00", {bus.rvalid0, bus.rvalid1});
    end
  endtask

  // Port 1 alone with lock: writes addr i with D_BASE+i, one command per cycle.
  task automatic test_lock_no_contention();
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i >= 1) begin
        vectors++;
        if ({bus.memEn, bus.memWrEn} !== 2'b11 || bus.memAddr !== 32'(i - 1)) begin
          miscompares++;
          $display("FAIL lock_solo_cmd[%0d]: en,we got %b addr %h want 11 addr %h",
                   i, {bus.memEn, bus.memWrEn}, bus.memAddr, 32'(i - 1));
        end
      end
      if (i == 10) begin
        vectors++;
        if (dut.burst_cnt !== 3'd4) begin
          miscompares++;
          $display("FAIL lock_solo_sat: burst_cnt got %0d want 4", dut.burst_cnt);
        end
        idle_inputs();
      end else begin
        bus.req1 = 1'b1; bus.lock1 = 1'b1; bus.wr1 = 1'b1;
        bus.addr1 = 32'(i); bus.wdata1 = D_BASE + 64'(i);
        #1;
        vectors++;
        if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
          miscompares++;
          $display("FAIL lock_solo_gnt[%0d]: gnt0,gnt1 got %b want 01", i, {bus.gnt0, bus.gnt1});
        end
      end
    end
    @(negedge clk);
    vectors++;
    if (bus.memEn !== 1'b0 || dut.burst_cnt !== 3'd0) begin
      miscompares++;
      $display("FAIL lock_solo_end: memEn got %b burst_cnt %0d want 0 and 0", bus.memEn, dut.burst_cnt);
    end
  endtask

  // Both ports read continuously; last grant was port 1, so port 0 leads.
  task automatic test_round_robin();
    logic exp_port [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 1 && i <= 6) begin
        vectors++;
        if ({bus.memEn, bus.memWrEn} !== 2'b10) begin
          miscompares++;
          $display("FAIL rr_cmd[%0d]: en,we got %b want 10", i, {bus.memEn, bus.memWrEn});
        end
      end
      if (i >= 2) begin
        vectors++;
        if ({bus.rvalid0, bus.rvalid1} !== {!exp_port[i-2], exp_port[i-2]} ||
            bus.mem_dout !== (exp_port[i-2] ? D_BASE + 64'd7 : D_BASE + 64'd4)) begin
          miscompares++;
          $display("FAIL rr_rvalid[%0d]: rvalid0,rvalid1 got %b data %h want %b data %h", i,
                   {bus.rvalid0, bus.rvalid1}, (exp_port[i-2] ? bus.rdata1 : bus.rdata0),
                   {!exp_port[i-2], exp_port[i-2]},
                   (exp_port[i-2] ? D_BASE + 64'd7 : D_BASE + 64'd4));
        end
      end
      if (i < 6) begin
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.wr0 = 1'b0; bus.wr1 = 1'b0;
        bus.addr0 = 32'd4; bus.addr1 = 32'd7;
        #1;
        vectors++;
        if ({bus.gnt0, bus.gnt1} !== {!exp_port[i], exp_port[i]}) begin
          miscompares++;
          $display("FAIL rr_gnt[%0d]: gnt0,gnt1 got %b want %b", i,
                   {bus.gnt0, bus.gnt1}, {!exp_port[i], exp_port[i]});
        end
      end else begin
        idle_inputs();
      end
    end
  endtask

  // Locked port 1 against a waiting processor: 4 grants, forced yield, repeat.
  task automatic test_burst_lock();
    logic exp_g1 [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 4 || i == 5) begin
        vectors++;
        if (dut.burst_cnt !== ((i == 4) ? 3'd4 : 3'd0)) begin
          miscompares++;
          $display("FAIL burst_cnt[%0d]: got %0d want %0d", i, dut.burst_cnt, (i == 4) ? 4 : 0);
        end
      end
      bus.req0 = 1'b1; bus.req1 = 1'b1; bus.lock1 = 1'b1;
      bus.wr0 = 1'b0; bus.wr1 = 1'b0; bus.addr0 = 32'd4; bus.addr1 = 32'd7;
      #1;
      vectors++;
      if ({bus.gnt0, bus.gnt1} !== {!exp_g1[i], exp_g1[i]}) begin
        miscompares++;
        $display("FAIL burst_gnt[%0d]: gnt0,gnt1 got %b want %b", i,
                 {bus.gnt0, bus.gnt1}, {!exp_g1[i], exp_g1[i]});
      end
    end
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
  endtask

  // Port 1 writes, port 0 reads the same address the very next cycle.
  task automatic test_back_to_back();
    @(negedge clk);
    bus.req1 = 1'b1; bus.wr1 = 1'b1; bus.addr1 = 32'h40; bus.wdata1 = D_XPORT;
    #1;
    vectors++;
    if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
      miscompares++;
      $display("FAIL b2b_wr_gnt: gnt0,gnt1 got %b want 01", {bus.gnt0, bus.gnt1});
    end
    @(negedge clk);
    idle_inputs();
    bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 32'h40;
    #1;
    vectors++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b_rd_gnt: gnt0,gnt1 got %b want 10", {bus.gnt0, bus.gnt1});
    end
    @(negedge clk);
    idle_inputs();
    vectors++;
    if ({bus.memEn, bus.memWrEn} !== 2'b10 || bus.memAddr !== 32'h40) begin
      miscompares++;
      $display("FAIL b2b_rd_cmd: en,we got %b addr %h want 10 addr 00000040",
               {bus.memEn, bus.memWrEn}, bus.memAddr);
    end
    @(negedge clk);
    vectors++;
    if ({bus.rvalid0, bus.rvalid1} !== 2'b10 || bus.rdata0 !== D_XPORT) begin
      miscompares++;
      $display("FAIL b2b_raw: rvalid0,rvalid1 got %b rdata0 %h want 10 rdata0 %h",
               {bus.rvalid0, bus.rvalid1}, bus.rdata0, D_XPORT);
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 32'h10;
    #1;
    vectors++;
    if (bus.gnt0 !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_gnt: gnt0 got %b want 1", bus.gnt0);
    end
    @(negedge clk);
    idle_inputs();
    vectors++;
    if (bus.memEn !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_cmd: memEn got %b want 1", bus.memEn);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.memEn !== 1'b0 || bus.memAddr !== 32'h0) begin
      miscompares++;
      $display("FAIL midrst_async: memEn got %b memAddr %h want 0 and 00000000", bus.memEn, bus.memAddr);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 1) reset = 1'b1;
      vectors++;
      if ({bus.rvalid0, bus.rvalid1} !== 2'b00) begin
        miscompares++;
        $display("FAIL midrst_rvalid[%0d]: rvalid0,rvalid1 got %b want 00", i, {bus.rvalid0, bus.rvalid1});
      end
    end
  endtask

  initial begin
    test_reset();
    test_solo_write_read();
    test_lock_no_contention();
    test_round_robin();
    test_burst_lock();
    test_back_to_back();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter that shares the single-ported data memory (dmem) between the four-stage processor (port 0) and the network interface / DMA engine (port 1) of a mesh node. Each requester holds a request until granted. The arbiter registers the winning command onto the dmem bus one cycle later and returns read data with a one-cycle valid pulse. A lock input lets port 1 perform bounded bursts, and a burst counter guarantees the processor is never starved.

## Interface
- DATA_W, 64, data width (bit 0 = MSB, [0:DATA_W-1] ordering)
- ADDR_W, 32, address width ([0:ADDR_W-1])
- MAX_BURST, 4, max consecutive locked grants to port 1 before a forced yield (≥1)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req0, req1  in  1  request from port n, held until gntn
- wr0, wr1  in  1  1 = write, 0 = read; valid with reqn
- addr0, addr1  in  ADDR_W  access address
- wdata0, wdata1  in  DATA_W  write data
- lock1  in  1  port 1 burst lock, meaningful only with req1
- gnt0, gnt1  out  1  combinational; command accepted this cycle
- rvalid0, rvalid1  out  1  registered; read data valid this cycle
- rdata0, rdata1  out  DATA_W  = mem_dout, qualified by rvalidn
- memEn  out  1  registered dmem enable
- memWrEn  out  1  registered dmem write enable
- memAddr  out  ADDR_W  registered dmem address
- memDataIn  out  DATA_W  registered dmem write data
- mem_dout  in  DATA_W  dmem dataOut, valid the cycle after a read edge

## Operation
- dmem model: synchronous; on a rising edge with memEn=1 it writes (memWrEn=1) or launches a read whose dataOut is valid in the following cycle.
- Arbitration, every cycle, combinational on req0/req1:
  - one requester -> it wins;
  - both -> the port not equal to `last` wins (round-robin);
  - exception: `locked` state (below) -> port 1 wins.
- Winner gets gntn=1 in the same cycle. At the rising edge: memEn<=1, memWrEn<=wrn, memAddr<=addrn, memDataIn<=wdatan, last<=n. No winner: memEn<=0, memWrEn<=0; address/data hold.
- Read tracking: 2-stage shift register of {valid, port}. Read granted in T -> memory edge ends T+1 -> rvalidn=1 in T+2, rdatan=mem_dout.
- Lock / burst control:
  - burst_cnt (width clog2(MAX_BURST+1)) increments on each gnt1 with lock1=1 and saturates at MAX_BURST.
  - `locked` = req1 & lock1 & (burst_cnt < MAX_BURST).
  - When burst_cnt == MAX_BURST and req0=1, port 0 wins, then burst_cnt clears.
  - burst_cnt also clears on any cycle with lock1=0 or req1=0.
  - If req0=0, port 1 keeps winning by the single-requester rule; burst_cnt stays saturated.
- rdata0/rdata1 both mirror mem_dout and have meaning only when rvalidn=1. rvalid0 and rvalid1 are never both 1.

## Timing
- Reset (reset=0, asynchronous): memEn=0, memWrEn=0, memAddr=0, memDataIn=0, rvalid0=rvalid1=0, read pipe cleared, last=1 (port 0 wins first tie), burst_cnt=0. gnt0/gnt1 stay combinational but are forced to 0 while reset=0.
- Reset deassertion is sampled synchronously. The first grant is possible in the first cycle with reset=1.
- Latency:
  - Request to gnt: 0 cycles if it wins.
  - Write committed at the edge ending T+1.
  - Read data is returned in T+2.
- Throughput: one access per cycle, back-to-back and mixed ports, no bubbles.
- Read after write to the same address, granted in consecutive cycles, returns the new data (dmem write edge precedes the read edge).
- Reset mid-operation: in-flight reads are dropped, and no rvalid is issued after reset.
- Requester changes req/wr/addr/wdata without a gnt: no effect on already-issued commands.

## Test plan
- Reset values: hold reset=0 for 5 cycles with req0=req1=1 -> gnt0=gnt1=0, memEn=0, rvalid0=rvalid1=0; first cycle after release -> gnt0=1.
- Solo write then read, port 0:
  - Write addr 0x10, data 0x0123456789ABCDEF at T -> memEn=memWrEn=1, memAddr=0x10 in T+1.
  - Read 0x10 at T+1 -> rvalid0=1 at T+3 with rdata0=0x0123456789ABCDEF.
- Round-robin: req0 and req1 held continuously with reads to distinct addresses -> grants alternate 0,1,0,1 with no idle cycle; rvalid port tags match, 2 cycles after each grant.
- Burst lock: MAX_BURST=4, req1+lock1 held, req0 asserted at the same time -> four gnt1, then one gnt0, then gnt1 resumes; burst_cnt back to 0 after the gnt0.
- Lock without contention: req1+lock1 for 10 cycles, req0=0 -> 10 consecutive gnt1, memEn=1 each following cycle.
- Reset mid-read: read granted at T, reset=0 during T+1 -> no rvalid in T+2; memEn=0 immediately at assertion.
